msg_char_streamer: RTL
======================

MSG_CHAR_STREAMER -- requirements
Module: msg_char_streamer

Interface
REQ-001 SHALL have parameter MSG_LEN, default 13, number of characters in the message (1..255).
REQ-002 SHALL have parameter MSG, default "SOY DE ZACAPA", packed 8*MSG_LEN bits; character 0 is the most-significant byte.
REQ-003 SHALL have parameter HOLD_W, default 4, width of the per-character hold setting.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 ena  input  1  design enable; low freezes all state (inputs are not acted on).
REQ-007 ui_in  input  8  [0] start, [1] loop mode (1 = loop, 0 = one-shot), [2] pause, [3] abort, [7:4] unused.
REQ-008 uio_in  input  8  [HOLD_W-1:0] hold setting; other bits unused.
REQ-009 uo_out  output  8  current character code (ASCII), registered.
REQ-010 uio_out  output  8  [4] busy, [5] char_strobe, [6] done, [7] wrap, [3:0] = 0; all registered.
REQ-011 uio_oe  output  8  constant 8'hF0.

Function
REQ-012 SHALL implement states IDLE, SHOW and DONE.
REQ-013 Start edge SHALL be detected as ui_in[0]=1 while the registered previous sample start_q=0; start_q updates every enabled cycle.
REQ-014 IDLE: start edge SHALL, at that clock edge, load idx=0, uo_out=MSG[0], char_strobe=1, busy=1, latch hold=uio_in[HOLD_W-1:0] and loop=ui_in[1], and enter SHOW.
REQ-015 SHOW: each character SHALL be displayed for hold+1 enabled, unpaused cycles (hold=0 gives one character per cycle).
REQ-016 SHOW: when the hold count expires and idx<MSG_LEN-1, the block SHALL increment idx, update uo_out to MSG[idx+1] and pulse char_strobe for one cycle.
REQ-017 SHOW: when the hold count expires at idx=MSG_LEN-1 with loop=1, the block SHALL set idx=0, output MSG[0], and pulse char_strobe and wrap together for one cycle.
REQ-018 SHOW: when the hold count expires at idx=MSG_LEN-1 with loop=0, the block SHALL enter DONE, set uo_out=8'h00, busy=0 and done=1.
REQ-019 Pause (ui_in[2]=1) in SHOW SHALL freeze idx, the hold counter and uo_out, and hold char_strobe and wrap at 0.
REQ-020 A start edge in SHOW SHALL be ignored.
REQ-021 DONE: done SHALL stay 1; a start edge SHALL restart exactly as in REQ-014, clearing done.
REQ-022 Abort (ui_in[3]=1) in any state SHALL force IDLE at the next edge, with uo_out=0 and busy, done, strobe and wrap all 0.
REQ-023 Abort SHALL win over a simultaneous start edge, pause or end-of-message.
REQ-024 ena=0 SHALL freeze every register, including start_q; strobes SHALL read 0 while frozen.
REQ-025 When MSG_LEN=1 and loop=1, wrap and char_strobe SHALL pulse every hold+1 cycles.
REQ-026 idx width SHALL be clog2(MSG_LEN) with a minimum of 1, and SHALL never exceed MSG_LEN-1.

Reset
REQ-027 rst_n low SHALL asynchronously clear the state to IDLE and set idx, the hold counter, start_q, latched hold and latched loop to 0.
REQ-028 rst_n low SHALL set uo_out=8'h00 and uio_out=8'h00.
REQ-029 Reset mid-SHOW SHALL abandon the message; after release, a new start edge is required to begin.
REQ-030 uio_oe SHALL read 8'hF0 during and after reset.

Verification
REQ-031 hold=0, loop=0, start pulse -> uo_out 0x53,0x4F,0x59,0x20,... on 13 consecutive cycles with char_strobe=1 each cycle, then 0x00 with done=1.
REQ-032 hold=3, loop=1 -> each character is held 4 cycles; after 'A' (0x41), 0x53 reappears with wrap=1 for one cycle; busy stays 1.
REQ-033 Pause asserted for 5 cycles mid-character -> uo_out is unchanged and the remaining hold time resumes exactly after pause is released.
REQ-034 Abort asserted in the same cycle as a start edge, and again mid-SHOW -> IDLE on the next edge, uo_out=0, uio_out[7:4]=0.
REQ-035 ena=0 for 10 cycles mid-message, plus start held high continuously -> no progress while ena=0 and no restart from the held level; rst_n pulse mid-SHOW -> all outputs 0 immediately.

Source files
------------

// File: rtl/msg_char_streamer.sv
// -----------------------------------------------------------------------------
// msg_char_streamer
//
// Streams a fixed ASCII message, one character at a time, onto an 8-bit
// output. Each character is held for a programmable number of cycles. The
// message can be played once (ending in DONE) or looped forever. Pause
// freezes playback, and abort returns to IDLE from any state.
//
// Parameters
//   MSG_LEN : number of characters in the message (1..255)
//   MSG     : packed message, character 0 in the most-significant byte
//   HOLD_W  : width of the per-character hold setting
//
// Ports
//   clk      : sole clock, rising edge
//   rst_n    : asynchronous active-low reset
//   ena      : design enable; low freezes every register
//   ui_in    : [0] start, [1] loop mode, [2] pause, [3] abort, [7:4] unused
//   uio_in   : [HOLD_W-1:0] hold setting (hold+1 cycles per character)
//   uo_out   : current character code (registered)
//   uio_out  : [4] busy, [5] char_strobe, [6] done, [7] wrap, [3:0] = 0
//   uio_oe   : constant 8'hF0 (upper nibble driven, lower nibble input)
// -----------------------------------------------------------------------------
module msg_char_streamer #(
    parameter int                    MSG_LEN = 13,
    parameter logic [8*MSG_LEN-1:0]  MSG     = "SOY DE ZACAPA",
    parameter int                    HOLD_W  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    // Index width is clog2(MSG_LEN), but never zero so a 1-character
    // message still has a legal index register.
    localparam int IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // -------------------------------------------------------------------------
    // Control input decode
    // -------------------------------------------------------------------------
    logic start_in;
    logic loop_in;
    logic pause_in;
    logic abort_in;
    logic [HOLD_W-1:0] hold_in;

    assign start_in = ui_in[0];
    assign loop_in  = ui_in[1];
    assign pause_in = ui_in[2];
    assign abort_in = ui_in[3];
    assign hold_in  = uio_in[HOLD_W-1:0];

    // Reserved input bits are collected here so they are visibly consumed.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, ui_in, uio_in};

    // -------------------------------------------------------------------------
    // Character lookup: shift the packed message so the wanted character
    // lands in the top byte. Character 0 lives in the MSB byte.
    // -------------------------------------------------------------------------
    function automatic logic [7:0] char_at(input logic [IDX_W-1:0] i);
        logic [8*MSG_LEN-1:0] shifted;
        shifted = MSG << (8 * i);
        return shifted[8*MSG_LEN-1 -: 8];
    endfunction

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    state_e            state_q,   state_d;
    logic [IDX_W-1:0]  idx_q,     idx_d;
    logic [HOLD_W-1:0] cnt_q,     cnt_d;
    logic [HOLD_W-1:0] hold_q,    hold_d;
    logic              loop_q,    loop_d;
    logic              start_q,   start_d;
    logic [7:0]        char_q,    char_d;
    logic              busy_q,    busy_d;
    logic              strobe_q,  strobe_d;
    logic              done_q,    done_d;
    logic              wrap_q,    wrap_d;

    logic start_edge;
    assign start_edge = start_in & ~start_q;

    // -------------------------------------------------------------------------
    // Next-state / output logic
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; a missing default in a combinational block infers a latch.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        loop_d   = loop_q;
        char_d   = char_q;
        busy_d   = busy_q;
        done_d   = done_q;
        strobe_d = 1'b0;       // strobes are single-cycle pulses
        wrap_d   = 1'b0;
        start_d  = start_in;   // previous-sample register for edge detect

        if (abort_in) begin
            // Abort outranks start edge, pause and end-of-message.
            state_d = ST_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            char_d  = 8'h00;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_edge) begin
                        state_d  = ST_SHOW;
                        idx_d    = '0;
                        cnt_d    = '0;
                        hold_d   = hold_in;
                        loop_d   = loop_in;
                        char_d   = char_at('0);
                        busy_d   = 1'b1;
                        done_d   = 1'b0;
                        strobe_d = 1'b1;
                    end
                end

                ST_SHOW: begin
                    // Start edges are ignored while showing.
                    if (!pause_in) begin
                        if (cnt_q == hold_q) begin
                            cnt_d = '0;
                            if (idx_q != LAST_IDX) begin
                                idx_d    = idx_q + IDX_W'(1);
                                char_d   = char_at(idx_q + IDX_W'(1));
                                strobe_d = 1'b1;
                            end else if (loop_q) begin
                                idx_d    = '0;
                                char_d   = char_at('0);
                                strobe_d = 1'b1;
                                wrap_d   = 1'b1;
                            end else begin
                                state_d = ST_DONE;
                                idx_d   = '0;
                                char_d  = 8'h00;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + HOLD_W'(1);
                        end
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    char_d  = 8'h00;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Register update; ena low holds every register, start_q included.
    // -------------------------------------------------------------------------
    // NOTE: non-blocking assignments here so every flop samples the values
    // from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            hold_q   <= '0;
            loop_q   <= 1'b0;
            start_q  <= 1'b0;
            char_q   <= 8'h00;
            busy_q   <= 1'b0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else if (ena) begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
            loop_q   <= loop_d;
            start_q  <= start_d;
            char_q   <= char_d;
            busy_q   <= busy_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            wrap_q   <= wrap_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. The pulse outputs are masked by ena so that a strobe captured
    // just before a freeze does not read as a continuous level while frozen.
    // -------------------------------------------------------------------------
    assign uo_out  = char_q;
    assign uio_out = {wrap_q & ena, done_q, strobe_q & ena, busy_q, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule
